// File: rtl/switch_toggle_pkg.sv
// Shared definitions for the multi-channel switch/LED toggler.
// Holds the edge-mode encodings and the debounce counter-width helper.
package switch_toggle_pkg;

    // Which debounced edge toggles an LED
    localparam int EDGE_RELEASE = 0;
    localparam int EDGE_PRESS   = 1;
    localparam int EDGE_BOTH    = 2;

    // Debounce counter width: max(1, $clog2(cycles)).
    // The counter only has to reach cycles-1, so this width never wraps.
    function automatic int cnt_width(input int cycles);
        if (cycles <= 2)
            return 1;
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Single-channel switch debouncer: optional 2-flop sync, counter, level.
// Ports: clk, rst_n (sync active-low), sw_raw (switch in), sw_db (level out).
// Config macro: SWITCH_TOGGLE_SYNC_EN adds a two-flop synchroniser.
module switch_debounce
    import switch_toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sw_s;
    logic [CW-1:0] cnt;
    logic          db;

`ifdef SWITCH_TOGGLE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], sw_raw};
    end

    assign sw_s = sync_q[1];
`else
    assign sw_s = sw_raw;
`endif

    // Any sample agreeing with the current level restarts filtering;
    // the level flips on the DEBOUNCE_CYCLES-th differing sample in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (sw_s == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= sw_s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sw_db = db;

endmodule

// File: rtl/switch_toggle_leds_n.sv
// NUM_CH debounced switches, each toggling its own LED on a chosen edge.
// Ports: i_Clk, i_Rst_L (sync active-low), i_Switch (raw),
//   o_LED (LED regs), o_Switch_Db (debounced), o_Toggle_Pulse (strobe).
// Config macro: SWITCH_TOGGLE_SYNC_EN (input synchronisers, +2 latency).
module switch_toggle_leds_n
    import switch_toggle_pkg::*;
#(
    parameter int                NUM_CH          = 4,
    parameter int                DEBOUNCE_CYCLES = 250000,
    parameter int                EDGE_MODE       = EDGE_RELEASE,
    parameter logic [NUM_CH-1:0] LED_INIT        = '0
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Switch_Db,
    output logic [NUM_CH-1:0] o_Toggle_Pulse
);

    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] db_prev;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] pulse;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (i_Clk),
            .rst_n (i_Rst_L),
            .sw_raw(i_Switch[n]),
            .sw_db (db[n])
        );
    end

    assign rise = db & ~db_prev;
    assign fall = ~db & db_prev;

    if (EDGE_MODE == EDGE_PRESS) begin : g_press
        assign trig = rise;
    end else if (EDGE_MODE == EDGE_BOTH) begin : g_both
        assign trig = rise | fall;
    end else begin : g_release
        assign trig = fall;
    end

    // Pulse is registered alongside the LED so it marks the cycle
    // in which the LED shows its new value.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            db_prev <= '0;
            led     <= LED_INIT;
            pulse   <= '0;
        end else begin
            db_prev <= db;
            led     <= led ^ trig;
            pulse   <= trig;
        end
    end

    assign o_LED          = led;
    assign o_Switch_Db    = db;
    assign o_Toggle_Pulse = pulse;

endmodule

// File: tb/tb_switch_toggle_leds_n.sv
// Directed bench for switch_toggle_leds_n (release mode + both-edge mode).
// Both DUTs share the switch inputs; expectations are hand-computed.
module tb_switch_toggle_leds_n;

`ifdef SWITCH_TOGGLE_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] led_a, db_a, pls_a;
    logic [3:0] led_b, db_b, pls_b;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    switch_toggle_leds_n #(
        .NUM_CH(4), .DEBOUNCE_CYCLES(4),
        .EDGE_MODE(0), .LED_INIT(4'b0000)
    ) dut_a (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
        .o_LED(led_a), .o_Switch_Db(db_a),
        .o_Toggle_Pulse(pls_a)
    );

    switch_toggle_leds_n #(
        .NUM_CH(4), .DEBOUNCE_CYCLES(4),
        .EDGE_MODE(2), .LED_INIT(4'b0101)
    ) dut_b (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
        .o_LED(led_b), .o_Switch_Db(db_b),
        .o_Toggle_Pulse(pls_b)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are then sampled 1ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] bounce;

    initial begin
        rst_n = 1'b0;
        sw    = 4'hF;

        // Reset held 3 cycles with all switches high
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_led", 32'(led_a), 32'h0);
            check("rst_db", 32'(db_a), 32'h0);
            check("rst_pls", 32'(pls_a), 32'h0);
        end
        check("rst_led_b", 32'(led_b), 32'h5);

        rst_n = 1'b1;
        sw    = 4'h0;
        step(2);
        check("idle_led", 32'(led_a), 32'h0);

        // Clean press on ch0
        sw[0] = 1'b1;
        step(3 + SL);
        check("p0_db_early", 32'(db_a[0]), 32'h0);
        step(1);
        check("p0_db", 32'(db_a[0]), 32'h1);
        check("p0_led", 32'(led_a[0]), 32'h0);
        check("b_p0_led_old", 32'(led_b[0]), 32'h1);
        step(1);
        check("p0_led_hold", 32'(led_a[0]), 32'h0);
        check("p0_pls", 32'(pls_a[0]), 32'h0);
        check("b_p0_led", 32'(led_b[0]), 32'h0);
        check("b_p0_pls", 32'(pls_b[0]), 32'h1);
        step(1);
        check("b_p0_pls_end", 32'(pls_b[0]), 32'h0);
        step(4);

        // Release ch0: LED toggles one edge after db falls
        sw[0] = 1'b0;
        step(3 + SL);
        check("r0_db_early", 32'(db_a[0]), 32'h1);
        step(1);
        check("r0_db", 32'(db_a[0]), 32'h0);
        check("r0_led_early", 32'(led_a[0]), 32'h0);
        check("r0_pls_early", 32'(pls_a[0]), 32'h0);
        step(1);
        check("r0_led", 32'(led_a[0]), 32'h1);
        check("r0_pls", 32'(pls_a[0]), 32'h1);
        check("b_r0_led", 32'(led_b[0]), 32'h1);
        check("b_r0_pls", 32'(pls_b[0]), 32'h1);
        step(1);
        check("r0_pls_end", 32'(pls_a[0]), 32'h0);
        check("r0_led_hold", 32'(led_a), 32'h1);

        // Bounce on ch1 never reaches 4 consecutive highs
        bounce = 8'b0111_0111;
        for (int i = 0; i < 8; i++) begin
            sw[1] = bounce[i];
            step(1);
            check("bnc_db", 32'(db_a[1]), 32'h0);
            check("bnc_pls", 32'(pls_a[1]), 32'h0);
        end
        sw[1] = 1'b0;
        step(4);
        check("bnc_db_end", 32'(db_a[1]), 32'h0);
        check("bnc_led", 32'(led_a), 32'h1);

        // Simultaneous ch2/ch3 press-release, twice
        sw[3:2] = 2'b11;
        step(10);
        check("sim_db", 32'(db_a), 32'hC);
        sw[3:2] = 2'b00;
        step(4 + SL);
        check("sim1_led_early", 32'(led_a), 32'h1);
        check("sim1_pls_early", 32'(pls_a), 32'h0);
        step(1);
        check("sim1_led", 32'(led_a), 32'hD);
        check("sim1_pls", 32'(pls_a), 32'hC);
        step(1);
        check("sim1_pls_end", 32'(pls_a), 32'h0);

        sw[3:2] = 2'b11;
        step(10);
        sw[3:2] = 2'b00;
        step(5 + SL);
        check("sim2_led", 32'(led_a), 32'h1);
        check("sim2_pls", 32'(pls_a), 32'hC);
        // Both-edge DUT saw two edges per channel: back to init
        check("b_sim2_led", 32'(led_b), 32'h5);
        step(2);

        // Reset again restores LED_INIT and clears state
        rst_n = 1'b0;
        step(1);
        check("rst2_led_a", 32'(led_a), 32'h0);
        check("rst2_led_b", 32'(led_b), 32'h5);
        check("rst2_pls_b", 32'(pls_b), 32'h0);
        rst_n = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
